// File: rtl/kws_act_pkg.sv
// Shared types and constants for the ReLU activation sequencer.
// Holds the FSM state encoding and default datapath widths.
package kws_act_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 10;

  // Sign bit of a default-width activation word
  localparam int SIGN_BIT = DATA_W_DEF - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_DONE,
    S_WRITE,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Clear/enable counter that flags the cycle in which it reaches LIMIT.
// Used to bound the wait for the ReLU responder's done pulse.
module seq_timeout_ctr #(
  parameter int LIMIT = 15,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != W'(LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // High in the cycle whose increment brings the count to LIMIT
  assign expire = en && !clr && (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/relu_sequencer.sv
// Walks a block of activation words through the ReLU responder
// and writes results back; counts negative words, flags timeouts.
module relu_sequencer
  import kws_act_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [LEN_W-1:0]  neg_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              act_start,
  output logic [DATA_W-1:0] act_data,
  input  logic [DATA_W-1:0] act_result,
  input  logic              act_done
);

  localparam int MsbIdx = SIGN_BIT + (DATA_W - DATA_W_DEF);

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  neg_q, neg_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic              busy_q, fin_q;
  logic              rd_en_q, wr_en_q, start_q;

  logic tmo_clr, tmo_en, tmo_exp;
  logic last_word;

  assign tmo_clr   = (state_q != S_WAIT_DONE);
  assign tmo_en    = (state_q == S_WAIT_DONE) && !act_done;
  assign last_word = (idx_q == len_q - LEN_W'(1));

  seq_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expire  (tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          idx_d   = '0;
          neg_d   = '0;
          err_d   = 1'b0;
          state_d = (len == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: state_d = S_WAIT_RD;
      S_WAIT_RD: begin
        opnd_d  = rd_data;
        neg_d   = neg_q + LEN_W'(rd_data[MsbIdx]);
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A done pulse in the expiry cycle still completes the word
        if (act_done) begin
          res_d   = act_result;
          state_d = S_WRITE;
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Addresses are registered alongside the state they belong to
  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    if (state_d == S_READ) begin
      rd_addr_d = src_d + ADDR_W'(idx_d);
    end
    if (state_d == S_WRITE) begin
      wr_addr_d = dst_d + ADDR_W'(idx_d);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      neg_q     <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      neg_q     <= neg_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      err_q     <= err_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= (state_d != S_IDLE);
      fin_q     <= (state_d == S_FINISH);
      rd_en_q   <= (state_d == S_READ);
      wr_en_q   <= (state_d == S_WRITE);
      start_q   <= (state_d == S_ISSUE);
    end
  end

  assign busy      = busy_q;
  assign finished  = fin_q;
  assign error     = err_q;
  assign neg_count = neg_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = res_q;
  assign act_start = start_q;
  assign act_data  = opnd_q;

endmodule

// File: tb/tb_relu_sequencer.sv
// Directed bench for relu_sequencer: SRAM and ReLU responder models,
// cycle-accurate job checks with immediate assertions.
module tb_relu_sequencer;

  localparam int DW  = 64;
  localparam int AW  = 10;
  localparam int LW  = 10;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, finished, error;
  logic [LW-1:0] neg_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          act_start;
  logic [DW-1:0] act_data;
  logic [DW-1:0] act_result;
  logic          act_done;

  logic [DW-1:0] mem [0:1023];
  int            resp_delay = 1;
  int            cd = 0;
  logic          stray = 1'b0;

  int nchk = 0;
  int nfail = 0;
  int nrd, nwr, busy_cnt, fin_cyc, fin_cnt, act_cnt;
  logic err_at1;
  logic [AW-1:0] rd_log [16];
  logic [AW-1:0] wa_log [16];
  logic [DW-1:0] wd_log [16];

  relu_sequencer #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .LEN_W   (LW),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (go),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len        (len),
    .busy       (busy),
    .finished   (finished),
    .error      (error),
    .neg_count  (neg_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .act_start  (act_start),
    .act_data   (act_data),
    .act_result (act_result),
    .act_done   (act_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Responder: done pulse arrives resp_delay cycles after act_start
  always @(posedge clk) begin
    if (act_start && resp_delay != 0) cd <= resp_delay;
    else if (cd != 0) cd <= cd - 1;
  end
  assign act_done   = (cd == 1) || stray;
  assign act_result = act_data[DW-1] ? '0 : act_data;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] n, input int dly,
                         input bit dup_go);
    resp_delay = dly;
    nrd = 0; nwr = 0; busy_cnt = 0;
    fin_cyc = -1; fin_cnt = 0; act_cnt = 0;
    @(negedge clk);
    src_base = s; dst_base = d; len = n; go = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      go = 1'b0;
      if (dup_go && c == 7) begin
        go = 1'b1; src_base = 10'h200; dst_base = 10'h200; len = 10'd1;
      end
      if (c == 1) err_at1 = error;
      if (busy) busy_cnt++;
      if (act_start) act_cnt++;
      if (rd_en) begin
        if (nrd < 16) rd_log[nrd] = rd_addr;
        nrd++;
      end
      if (wr_en) begin
        if (nwr < 16) begin
          wa_log[nwr] = wr_addr;
          wd_log[nwr] = wr_data;
        end
        nwr++;
      end
      if (finished) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = c;
      end
      @(negedge clk);
    end
    go = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    mem[10'h010] = 64'd5;
    mem[10'h011] = 64'hFFFF_FFFF_FFFF_FFFD;
    mem[10'h012] = 64'd0;
    mem[10'h013] = 64'h7FFF_FFFF_FFFF_FFFF;
    mem[10'h020] = 64'h8000_0000_0000_0001;
    mem[10'h030] = 64'h1234;
    mem[10'h3FE] = 64'd1;
    mem[10'h3FF] = 64'hFFFF_FFFF_FFFF_FFFE;
    mem[10'h000] = 64'd3;
    mem[10'h001] = 64'd4;
    mem[10'h050] = 64'h77;

    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, finished, error, rd_en, wr_en, act_start,
                    neg_count, rd_addr, wr_addr}, 64'd0);
    chk("rst_wdata", wr_data, 64'd0);
    chk("rst_adata", act_data, 64'd0);
    reset_n = 1'b1;

    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(negedge clk);
    chk("stray_done", {busy, rd_en, wr_en, act_start}, 64'd0);

    run_job(10'h010, 10'h080, 10'd4, 1, 1'b0);
    chk("t1_fin_cyc", 64'(fin_cyc), 64'd21);
    chk("t1_fin_cnt", 64'(fin_cnt), 64'd1);
    chk("t1_busy_cyc", 64'(busy_cnt), 64'd21);
    chk("t1_nwr", 64'(nwr), 64'd4);
    chk("t1_act_cnt", 64'(act_cnt), 64'd4);
    chk("t1_waddr", {wa_log[0], wa_log[1], wa_log[2], wa_log[3]},
        {10'h080, 10'h081, 10'h082, 10'h083});
    chk("t1_w0", wd_log[0], 64'd5);
    chk("t1_w1", wd_log[1], 64'd0);
    chk("t1_w2", wd_log[2], 64'd0);
    chk("t1_w3", wd_log[3], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t1_neg", 64'(neg_count), 64'd1);
    chk("t1_err", 64'(error), 64'd0);

    run_job(10'h010, 10'h080, 10'd0, 1, 1'b0);
    chk("t2_fin_cyc", 64'(fin_cyc), 64'd1);
    chk("t2_nrd", 64'(nrd), 64'd0);
    chk("t2_nwr", 64'(nwr), 64'd0);
    chk("t2_neg", 64'(neg_count), 64'd0);
    chk("t2_err", 64'(error), 64'd0);

    run_job(10'h020, 10'h090, 10'd2, 0, 1'b0);
    chk("t3_fin_cyc", 64'(fin_cyc), 64'(3 + TMO + 1));
    chk("t3_nwr", 64'(nwr), 64'd0);
    chk("t3_nrd", 64'(nrd), 64'd1);
    chk("t3_err", 64'(error), 64'd1);
    chk("t3_neg", 64'(neg_count), 64'd1);

    run_job(10'h030, 10'h040, 10'd1, TMO, 1'b0);
    chk("t4_err_clr", 64'(err_at1), 64'd0);
    chk("t4_fin_cyc", 64'(fin_cyc), 64'd20);
    chk("t4_nwr", 64'(nwr), 64'd1);
    chk("t4_waddr", 64'(wa_log[0]), 64'h040);
    chk("t4_wdata", wd_log[0], 64'h1234);
    chk("t4_err", 64'(error), 64'd0);

    run_job(10'h3FE, 10'h100, 10'd4, 1, 1'b1);
    chk("t5_nrd", 64'(nrd), 64'd4);
    chk("t5_raddr", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]},
        {10'h3FE, 10'h3FF, 10'h000, 10'h001});
    chk("t5_fin_cyc", 64'(fin_cyc), 64'd21);
    chk("t5_nwr", 64'(nwr), 64'd4);
    chk("t5_waddr3", 64'(wa_log[3]), 64'h103);
    chk("t5_w1", wd_log[1], 64'd0);
    chk("t5_w2", wd_log[2], 64'd3);
    chk("t5_neg", 64'(neg_count), 64'd1);

    resp_delay = 0;
    @(negedge clk);
    src_base = 10'h050; dst_base = 10'h060; len = 10'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_in_wait", {busy, act_start, wr_en}, {1'b1, 1'b0, 1'b0});
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {busy, finished, error, rd_en, wr_en, act_start,
                       neg_count, rd_addr, wr_addr}, 64'd0);
    chk("t6_rst_adata", act_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nrd = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en || wr_en || busy) nrd++;
    end
    chk("t6_quiet", 64'(nrd), 64'd0);

    run_job(10'h050, 10'h060, 10'd1, 1, 1'b0);
    chk("t6_fin_cyc", 64'(fin_cyc), 64'd6);
    chk("t6_nwr", 64'(nwr), 64'd1);
    chk("t6_wdata", wd_log[0], 64'h77);
    chk("t6_waddr", 64'(wa_log[0]), 64'h060);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/relu_sequencer.md
# relu_sequencer

Initiator side of the activation start/done handshake: walks a block of 64-bit activation words in the on-chip activation SRAM, hands each word to the ReLU responder, and writes each result back to a destination region. It sits between the layer controller, which issues `go` and receives `finished`, and the ReLU unit plus activation memory. It also counts zeroed (negative) words as a sparsity statistic and flags a responder that never answers.

## Interface
Parameters:
- `DATA_W`, default 64: activation word width; must match the responder.
- `ADDR_W`, default 10: SRAM address width.
- `LEN_W`, default 10: width of the word-count input.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `act_done` before aborting.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: single-cycle start request; sampled only in IDLE.
- `src_base` in ADDR_W: first source address; latched on accepted `go`.
- `dst_base` in ADDR_W: first destination address; latched on accepted `go`.
- `len` in LEN_W: number of words; latched on accepted `go`.
- `busy` out 1: high in every state except IDLE.
- `finished` out 1: one-cycle pulse at the end of every accepted job.
- `error` out 1: sticky timeout flag; cleared on the next accepted `go`.
- `neg_count` out LEN_W: number of words with MSB=1 in the last or current job; cleared on accepted `go`.
- `rd_en` out 1, `rd_addr` out ADDR_W, `rd_data` in DATA_W: synchronous SRAM read port with 1-cycle read latency.
- `wr_en` out 1, `wr_addr` out ADDR_W, `wr_data` out DATA_W: SRAM write port.
- `act_start` out 1, `act_data` out DATA_W: request to the responder.
- `act_result` in DATA_W, `act_done` in 1: responder reply; `act_result` is valid while `act_done` is high.

## Operation
- States: IDLE, READ, WAIT_RD, ISSUE, WAIT_DONE, WRITE, FINISH.
- IDLE → READ on `go` with `len` != 0. IDLE → FINISH on `go` with `len` == 0: no reads or writes, `finished` pulses, `error` = 0.
- READ: `rd_en`=1, `rd_addr` = `src_base` + idx. Next state WAIT_RD.
- WAIT_RD: capture `rd_data` into the operand register. Increment `neg_count` if operand MSB = 1. Next state ISSUE.
- ISSUE: `act_start`=1 for exactly one cycle; `act_data` = operand register, held stable until WRITE. Next state WAIT_DONE.
- WAIT_DONE: on `act_done`, capture `act_result` and go to WRITE. Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT: set `error`, go to FINISH, and skip the write for this word and all remaining words.
  - `act_done` in the same cycle as expiry: `act_done` wins, no error.
- WRITE: `wr_en`=1, `wr_addr` = `dst_base` + idx, `wr_data` = captured result. If idx == len-1 go to FINISH; else idx+1 and go to READ.
- FINISH: `finished`=1 for one cycle, then IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. `src_base` == `dst_base` (in-place operation) is legal.
- `go` while busy is ignored, and the latched parameters do not change.
- `act_done` outside WAIT_DONE is ignored.

## Timing
- Reset values: `busy`, `finished`, `error`, `rd_en`, `wr_en`, `act_start` = 0; `neg_count`, `rd_addr`, `wr_addr`, `wr_data`, `act_data` = 0; state IDLE.
- Reset mid-job aborts immediately. No further read or write is issued after release.
- All outputs are registered. Each state lasts one cycle, except WAIT_DONE, which lasts 1 to TIMEOUT cycles.
- With `go` accepted at edge 0 and a responder that asserts `act_done` the cycle after `act_start`:
  - Each word takes 5 cycles.
  - Word i's WRITE is in cycle 5i+5.
  - `finished` is in cycle 5·len+1.
  - `busy` is high in cycles 1 through 5·len+1.
- Timeout abort: `finished` follows TIMEOUT cycles of WAIT_DONE by exactly one cycle; `error` rises in the same cycle as `finished`.

## Structure
- Package `kws_act_pkg` holds the state enum, the default DATA_W/ADDR_W/LEN_W constants, and the MSB-index constant for the sign test.
- One sub-module, `seq_timeout_ctr`: a clear/enable/expire counter of width clog2(TIMEOUT+1), instantiated for WAIT_DONE.

## Test plan
- `len`=4, `src_base`=0x10, `dst_base`=0x80, words {5, −3, 0, 0x7FFF…F}, 1-cycle responder → writes {5, 0, 0, 0x7FFF…F} at 0x80..0x83, `neg_count`=1, `finished` in cycle 21.
- `len`=0 → `finished` in cycle 1, no `rd_en`/`wr_en`, `neg_count`=0.
- Responder holds `act_done` low → `error`=1 and `finished` in cycle 3+TIMEOUT+1, zero writes. Next `go` clears `error`.
- Responder delays `act_done` exactly TIMEOUT cycles → word written, `error`=0.
- `src_base`=0x3FE, `len`=4 → reads 0x3FE, 0x3FF, 0x000, 0x001. A second `go` during busy is ignored.
- `reset_n` low during WAIT_DONE → all outputs return to reset values, no write after release, and a fresh `go` runs normally.
